// File: rtl/naca_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard source: FSM states, prefix codes
// and the layout of the key event word handed to the register file.
package naca_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kbd_state_e;

  localparam logic [7:0] KBD_PFX_EXT = 8'hE0;
  localparam logic [7:0] KBD_PFX_REL = 8'hF0;

  localparam int KBD_VALID_BIT = 31;
  localparam int KBD_REL_BIT   = 9;
  localparam int KBD_EXT_BIT   = 8;

  // Build the event word; the valid bit keeps it non-zero for any scan code.
  function automatic logic [31:0] kbd_event_word(input logic rel, input logic ext,
                                                 input logic [7:0] code);
    logic [31:0] word;
    word                = '0;
    word[KBD_VALID_BIT] = 1'b1;
    word[KBD_REL_BIT]   = rel;
    word[KBD_EXT_BIT]   = ext;
    word[7:0]           = code;
    return word;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus glitch filter for one raw PS/2 line. The filtered level
// only changes after FILTER_LEN consecutive synchronised samples disagree with
// it; fall pulses for one clk when the filtered level goes 1 -> 0.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   level_reg;
  logic                   fall_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // Synchroniser chain; idles high like an undriven PS/2 line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (sync_out == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
        cnt_reg   <= '0;
        level_reg <= sync_out;
        fall_reg  <= level_reg & ~sync_out;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_keyboard_source.sv
// PS/2 keyboard receiver producing the one-clk key event word for the
// register file, with E0/F0 prefix tracking, frame error pulses and a
// saturating error counter.
module ps2_keyboard_source
  import naca_kbd_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYC    = 50000,
  parameter bit REPORT_RELEASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyboard,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic        clk_level, clk_fall;
  logic        data_level, data_fall;
  logic        edge_evt, data_bit;

  kbd_state_e  state_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        parity_reg;
  logic [TW-1:0] tcnt_reg;
  logic        ext_reg, rel_reg;
  logic [31:0] keyboard_reg;
  logic        frame_err_reg;
  logic [7:0]  err_cnt_reg;

  logic        timeout, frame_good, stop_bad, err_now;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ps2_clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ps2_data),
    .level (data_level),
    .fall  (data_fall)
  );

  // A fall pulse always coincides with a low filtered level, so these
  // qualifiers do not alter the edge or the sampled bit.
  assign edge_evt = clk_fall & ~clk_level;
  assign data_bit = data_level & ~data_fall;

  assign timeout    = (state_reg != ST_IDLE) && !edge_evt && (tcnt_reg == TW'(TIMEOUT_CYC - 1));
  assign frame_good = ((^shift_reg) ^ parity_reg) & data_bit;
  assign stop_bad   = edge_evt && (state_reg == ST_STOP) && !frame_good;
  assign err_now    = timeout | stop_bad;

  // Frame timeout counter: runs only mid-frame, restarted by every clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_reg <= '0;
    end else if (state_reg == ST_IDLE || edge_evt) begin
      tcnt_reg <= '0;
    end else begin
      tcnt_reg <= tcnt_reg + 1'b1;
    end
  end

  // Frame FSM, prefix tracking and one-clk output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      ext_reg       <= 1'b0;
      rel_reg       <= 1'b0;
      keyboard_reg  <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      keyboard_reg  <= '0;
      frame_err_reg <= err_now;
      if (timeout) begin
        // Partial byte dropped; prefixes survive a stalled frame.
        state_reg <= ST_IDLE;
      end else if (edge_evt) begin
        case (state_reg)
          ST_IDLE: begin
            bit_cnt_reg <= '0;
            if (!data_bit) state_reg <= ST_DATA;
          end
          ST_DATA: begin
            shift_reg   <= {data_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_reg <= data_bit;
            state_reg  <= ST_STOP;
          end
          ST_STOP: begin
            state_reg <= ST_IDLE;
            if (!frame_good) begin
              ext_reg <= 1'b0;
              rel_reg <= 1'b0;
            end else if (shift_reg == KBD_PFX_EXT) begin
              ext_reg <= 1'b1;
            end else if (shift_reg == KBD_PFX_REL) begin
              rel_reg <= 1'b1;
            end else begin
              ext_reg <= 1'b0;
              rel_reg <= 1'b0;
              if (REPORT_RELEASE || !rel_reg)
                keyboard_reg <= kbd_event_word(rel_reg, ext_reg, shift_reg);
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // Saturating frame error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (err_now && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign keyboard  = keyboard_reg;
  assign frame_err = frame_err_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_ps2_keyboard_source.sv
// Directed bench for ps2_keyboard_source: two instances share the PS/2 pins,
// one reporting releases and one discarding them.
module tb_ps2_keyboard_source;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyboard, keyboard2;
  logic        frame_err, frame_err2;
  logic [7:0]  err_cnt, err_cnt2;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  // event monitor state
  int          ev_cnt = 0, ev_cnt2 = 0, err_pulses = 0, long_cnt = 0;
  logic [31:0] last_ev = '0, prev_ev = '0, last_ev2 = '0;
  logic        kb_prev = 1'b0, fe_prev = 1'b0, kb2_prev = 1'b0;

  ps2_keyboard_source #(.TIMEOUT_CYC(TMO), .REPORT_RELEASE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard(keyboard), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  ps2_keyboard_source #(.TIMEOUT_CYC(TMO), .REPORT_RELEASE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard(keyboard2), .frame_err(frame_err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  // Record events and error pulses; any output high two clks in a row is a violation.
  always @(negedge clk) begin
    if (keyboard != 32'd0) begin
      ev_cnt  = ev_cnt + 1;
      prev_ev = last_ev;
      last_ev = keyboard;
      if (kb_prev) long_cnt = long_cnt + 1;
    end
    kb_prev = (keyboard != 32'd0);
    if (keyboard2 != 32'd0) begin
      ev_cnt2  = ev_cnt2 + 1;
      last_ev2 = keyboard2;
      if (kb2_prev) long_cnt = long_cnt + 1;
    end
    kb2_prev = (keyboard2 != 32'd0);
    if (frame_err) begin
      err_pulses = err_pulses + 1;
      if (fe_prev) long_cnt = long_cnt + 1;
    end
    fe_prev = frame_err;
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (5) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ par_flip);
    send_bit(stop_v);
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    cmp_cnt++;
    if (keyboard !== 32'd0) begin fail_cnt++; $display("FAIL reset_keyboard got %h want 0", keyboard); end
    cmp_cnt++;
    if (frame_err !== 1'b0) begin fail_cnt++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    cmp_cnt++;
    if (err_cnt !== 8'd0) begin fail_cnt++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    $display("reset: checked idle outputs");
  endtask

  task automatic test_make();
    int n0, e0;
    n0 = ev_cnt; e0 = err_pulses;
    send_frame(8'h1C, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt !== n0 + 1) begin fail_cnt++; $display("FAIL make_count got %0d want %0d", ev_cnt - n0, 1); end
    cmp_cnt++;
    if (last_ev !== 32'h8000_001C) begin fail_cnt++; $display("FAIL make_word got %h want 8000001c", last_ev); end
    cmp_cnt++;
    if (err_pulses !== e0) begin fail_cnt++; $display("FAIL make_err got %0d want 0", err_pulses - e0); end
    $display("make 1C: word %h", last_ev);
  endtask

  task automatic test_prefix();
    int n0;
    n0 = ev_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt !== n0) begin fail_cnt++; $display("FAIL prefix_e0 got %0d events want 0", ev_cnt - n0); end
    send_frame(8'hF0, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt !== n0) begin fail_cnt++; $display("FAIL prefix_f0 got %0d events want 0", ev_cnt - n0); end
    send_frame(8'h75, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt !== n0 + 1) begin fail_cnt++; $display("FAIL prefix_count got %0d want 1", ev_cnt - n0); end
    cmp_cnt++;
    if (last_ev !== 32'h8000_0375) begin fail_cnt++; $display("FAIL prefix_word got %h want 80000375", last_ev); end
    $display("E0 F0 75: word %h", last_ev);
  endtask

  task automatic test_parity_err();
    int n0, e0;
    n0 = ev_cnt; e0 = err_pulses;
    send_frame(8'h1C, 1'b1, 1'b1);
    cmp_cnt++;
    if (err_pulses !== e0 + 1) begin fail_cnt++; $display("FAIL parity_pulse got %0d want 1", err_pulses - e0); end
    cmp_cnt++;
    if (err_cnt !== 8'd1) begin fail_cnt++; $display("FAIL parity_err_cnt got %0d want 1", err_cnt); end
    cmp_cnt++;
    if (ev_cnt !== n0) begin fail_cnt++; $display("FAIL parity_event got %0d want 0", ev_cnt - n0); end
    send_frame(8'h29, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt !== n0 + 1) begin fail_cnt++; $display("FAIL parity_next_count got %0d want 1", ev_cnt - n0); end
    cmp_cnt++;
    if (last_ev !== 32'h8000_0029) begin fail_cnt++; $display("FAIL parity_next_word got %h want 80000029", last_ev); end
    $display("parity error then 29: err_cnt %0d word %h", err_cnt, last_ev);
  endtask

  task automatic test_stop_err();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    cmp_cnt++;
    if (err_cnt !== 8'd2) begin fail_cnt++; $display("FAIL stop_err_cnt got %0d want 2", err_cnt); end
    send_frame(8'h1C, 1'b0, 1'b1);
    cmp_cnt++;
    if (last_ev !== 32'h8000_001C) begin fail_cnt++; $display("FAIL stop_clears_rel got %h want 8000001c", last_ev); end
    $display("F0, bad stop, 1C: word %h", last_ev);
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TMO + 20) @(posedge clk);
    cmp_cnt++;
    if (err_pulses !== e0 + 1) begin fail_cnt++; $display("FAIL timeout_pulse got %0d want 1", err_pulses - e0); end
    cmp_cnt++;
    if (err_cnt !== 8'd3) begin fail_cnt++; $display("FAIL timeout_err_cnt got %0d want 3", err_cnt); end
    send_frame(8'h5A, 1'b0, 1'b1);
    cmp_cnt++;
    if (last_ev !== 32'h8000_005A) begin fail_cnt++; $display("FAIL timeout_next got %h want 8000005a", last_ev); end
    $display("timeout then 5A: err_cnt %0d word %h", err_cnt, last_ev);
  endtask

  task automatic test_release_filter();
    int m0;
    m0 = ev_cnt2;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt2 !== m0) begin fail_cnt++; $display("FAIL norel_break got %0d events want 0", ev_cnt2 - m0); end
    cmp_cnt++;
    if (last_ev !== 32'h8000_021C) begin fail_cnt++; $display("FAIL rel_word got %h want 8000021c", last_ev); end
    send_frame(8'h1C, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt2 !== m0 + 1) begin fail_cnt++; $display("FAIL norel_make_count got %0d want 1", ev_cnt2 - m0); end
    cmp_cnt++;
    if (last_ev2 !== 32'h8000_001C) begin fail_cnt++; $display("FAIL norel_make_word got %h want 8000001c", last_ev2); end
    $display("release filter: dut2 word %h", last_ev2);
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = ev_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(logic'((8'h16 >> i) & 8'h01));
    send_bit(~^8'h16);
    send_bit(1'b1);
    send_frame(8'h45, 1'b0, 1'b1);
    cmp_cnt++;
    if (ev_cnt !== n0 + 2) begin fail_cnt++; $display("FAIL b2b_count got %0d want 2", ev_cnt - n0); end
    cmp_cnt++;
    if (prev_ev !== 32'h8000_0016) begin fail_cnt++; $display("FAIL b2b_first got %h want 80000016", prev_ev); end
    cmp_cnt++;
    if (last_ev !== 32'h8000_0045) begin fail_cnt++; $display("FAIL b2b_second got %h want 80000045", last_ev); end
    $display("back to back: %h %h", prev_ev, last_ev);
  endtask

  task automatic test_reset_mid_frame();
    int n0, e0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (err_cnt !== 8'd0) begin fail_cnt++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); end
    cmp_cnt++;
    if (keyboard !== 32'd0) begin fail_cnt++; $display("FAIL midrst_keyboard got %h want 0", keyboard); end
    cmp_cnt++;
    if (frame_err !== 1'b0) begin fail_cnt++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    n0 = ev_cnt; e0 = err_pulses;
    repeat (TMO + 20) @(posedge clk);
    cmp_cnt++;
    if (ev_cnt !== n0 || err_pulses !== e0) begin
      fail_cnt++; $display("FAIL midrst_quiet got %0d events %0d errors want 0 0", ev_cnt - n0, err_pulses - e0);
    end
    send_frame(8'h16, 1'b0, 1'b1);
    cmp_cnt++;
    if (last_ev !== 32'h8000_0016) begin fail_cnt++; $display("FAIL midrst_next got %h want 80000016", last_ev); end
    $display("reset mid frame then 16: word %h", last_ev);
  endtask

  initial begin
    test_reset();
    test_make();
    test_prefix();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_release_filter();
    test_back_to_back();
    test_reset_mid_frame();
    cmp_cnt++;
    if (long_cnt !== 0) begin fail_cnt++; $display("FAIL pulse_width got %0d long pulses want 0", long_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
